m68k_bus_initiator: RTL and testbench

// - Bus master that runs 68000-style asynchronous bus cycles (AS/UDS/LDS/RW, DTACK-terminated) from a simple request port.
// - Initiator end of the interface that dram_controller and other DTACK responders serve.
// - Used by DMA/refresh-test logic and as a synthesizable stimulus engine for DRAM bring-up.
// - Handles 8/16-bit reads and writes, DTACK synchronisation and bus-timeout (BERR-style) reporting.

---
 rtl/m68k_bus_pkg.sv | 25 ++
 rtl/sync2.sv | 25 ++
 rtl/m68k_bus_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_m68k_bus_initiator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus initiator: state encoding,
// byte-lane indices and the default bus-timeout length.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_STRB    = 3'd2,
        S_WAIT    = 3'd3,
        S_LATCH   = 3'd4,
        S_RELEASE = 3'd5,
        S_RECOVER = 3'd6,
        S_REJECT  = 3'd7
    } state_e;

    localparam int BE_UPPER               = 1;
    localparam int BE_LOWER               = 0;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Active-low {UDS, LDS} strobe pattern for a pair of byte enables.
    function automatic logic [1:0] ds_n(input logic [1:0] be);
        return {~be[BE_UPPER], ~be[BE_LOWER]};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an active-low asynchronous input; resets to the
// inactive (high) level so nothing downstream sees a spurious assertion.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_initiator.sv
// Bus master running 68000-style AS/UDS/LDS/RW cycles terminated by DTACK,
// with timeout reporting in both the data phase and the DTACK-release phase.
module m68k_bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [22:0] REQ_ADDR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        READY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [22:0] ADDR_OUT,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DTACK
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rd_q, rd_d;
    logic [1:0]       be_q, be_d;
    logic             as_q, as_d;
    logic             uds_q, uds_d;
    logic             lds_q, lds_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic [22:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             dtack_s;
    logic             ready;
    logic             done;
    logic             err_out;

    sync2 u_dtack_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (DTACK),
        .q_o   (dtack_s)
    );

    // Never start a cycle while the previous responder still holds DTACK low.
    assign ready = (state_q == S_IDLE) && dtack_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        be_d    = be_q;
        as_d    = as_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done    = 1'b0;
        err_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ && ready) begin
                    rd_d  = REQ_RW;
                    be_d  = REQ_BE;
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (REQ_BE == 2'b00) begin
                        state_d = S_REJECT;
                    end else begin
                        addr_d = REQ_ADDR;
                        rw_d   = REQ_RW;
                        if (!REQ_RW) begin
                            wdata_d = REQ_WDATA;
                            oe_d    = 1'b1;
                        end
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                as_d = 1'b0;
                if (rd_q) {uds_d, lds_d} = ds_n(be_q);
                state_d = S_STRB;
            end
            S_STRB: begin
                // Write strobes trail AS by a clock so DATA_OUT is settled first.
                if (!rd_q) {uds_d, lds_d} = ds_n(be_q);
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!dtack_s) begin
                    state_d = S_LATCH;
                end else if (cnt_q == CNT_LAST) begin
                    err_d               = 1'b1;
                    {as_d, uds_d, lds_d} = 3'b111;
                    state_d             = S_RELEASE;
                end
            end
            S_LATCH: begin
                if (rd_q) rdata_d = DATA_IN;
                {as_d, uds_d, lds_d} = 3'b111;
                state_d              = S_RELEASE;
            end
            S_RELEASE: begin
                cnt_d   = '0;
                oe_d    = 1'b0;
                rw_d    = 1'b1;
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                cnt_d = cnt_q + 1'b1;
                if (dtack_s) begin
                    done    = 1'b1;
                    err_out = err_q;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done    = 1'b1;
                    err_out = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REJECT: begin
                // One quiet clock after acceptance, then report the empty request.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    done    = 1'b1;
                    err_out = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b1;
            be_q    <= 2'b00;
            as_q    <= 1'b1;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            be_q    <= be_d;
            as_q    <= as_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign READY    = ready;
    assign DONE     = done;
    assign ERR      = err_out;
    assign RDATA    = rdata_q;
    assign ADDR_OUT = addr_q;
    assign AS       = as_q;
    assign UDS      = uds_q;
    assign LDS      = lds_q;
    assign RW       = rw_q;
    assign DATA_OUT = wdata_q;
    assign DATA_OE  = oe_q;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: a small DTACK responder plus
// per-scenario tasks with hand-computed cycle positions.
module tb_m68k_bus_initiator;

    logic        CLK;
    logic        RST;
    logic        REQ;
    logic        REQ_RW;
    logic [22:0] REQ_ADDR;
    logic [1:0]  REQ_BE;
    logic [15:0] REQ_WDATA;
    logic        READY;
    logic        DONE;
    logic        ERR;
    logic [15:0] RDATA;
    logic [22:0] ADDR_OUT;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;
    logic [15:0] DATA_IN;
    logic        DTACK;

    int total;
    int bad;

    typedef struct {
        int          c_done;
        int          ndone;
        logic        err;
        logic [15:0] rdata;
        int          c_as;
        int          c_uds;
        int          c_lds;
        int          c_rise;
        int          n_as_fall;
        logic        oe_pre;
        logic        rw_bad;
        logic        addr_bad;
        logic        dout_bad;
    } obs_t;

    m68k_bus_initiator #(.TIMEOUT_CYCLES(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_RW    (REQ_RW),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_BE    (REQ_BE),
        .REQ_WDATA (REQ_WDATA),
        .READY     (READY),
        .DONE      (DONE),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .ADDR_OUT  (ADDR_OUT),
        .AS        (AS),
        .UDS       (UDS),
        .LDS       (LDS),
        .RW        (RW),
        .DATA_OUT  (DATA_OUT),
        .DATA_OE   (DATA_OE),
        .DATA_IN   (DATA_IN),
        .DTACK     (DTACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issues one request and plays responder for ncyc clocks. Cycle c counts
    // falling edges after the accepting rising edge (c=1 is the first).
    // DTACK falls asr_dly clocks after AS is seen low and rises one clock after
    // AS is seen high again unless stuck. REQ is re-pulsed at c==pulse_at.
    task automatic run_bus(input logic rw, input logic [22:0] addr, input logic [1:0] be,
                           input logic [15:0] wdata, input logic [15:0] din,
                           input int asr_dly, input bit stuck, input int pulse_at,
                           input int ncyc, output obs_t o);
        logic prev_as;
        logic prev_oe;
        o.c_done = -1; o.ndone = 0; o.err = 1'b0; o.rdata = 16'h0;
        o.c_as = -1; o.c_uds = -1; o.c_lds = -1; o.c_rise = -1; o.n_as_fall = 0;
        o.oe_pre = 1'b0; o.rw_bad = 1'b0; o.addr_bad = 1'b0; o.dout_bad = 1'b0;
        @(negedge CLK);
        REQ = 1'b1; REQ_RW = rw; REQ_ADDR = addr; REQ_BE = be; REQ_WDATA = wdata; DATA_IN = din;
        prev_as = AS;
        prev_oe = DATA_OE;
        @(negedge CLK);
        REQ = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (DONE === 1'b1) begin
                o.ndone++;
                if (o.c_done < 0) begin
                    o.c_done = c;
                    o.err    = ERR;
                    o.rdata  = RDATA;
                end
            end
            if (AS === 1'b0 && prev_as === 1'b1) o.n_as_fall++;
            if (AS === 1'b0 && o.c_as < 0) o.c_as = c;
            if ((UDS === 1'b0 || LDS === 1'b0) && o.c_uds < 0 && o.c_lds < 0) o.oe_pre = prev_oe;
            if (UDS === 1'b0 && o.c_uds < 0) o.c_uds = c;
            if (LDS === 1'b0 && o.c_lds < 0) o.c_lds = c;
            if (AS === 1'b0) begin
                if (ADDR_OUT !== addr) o.addr_bad = 1'b1;
                if (RW !== rw) o.rw_bad = 1'b1;
                if (!rw && DATA_OUT !== wdata) o.dout_bad = 1'b1;
            end
            if (o.c_as >= 0 && AS === 1'b1 && o.c_rise < 0) o.c_rise = c;
            if (asr_dly >= 0 && o.c_as >= 0 && c == o.c_as + asr_dly) DTACK = 1'b0;
            if (!stuck && o.c_rise >= 0 && c == o.c_rise + 1) DTACK = 1'b1;
            REQ = (c == pulse_at);
            prev_as = AS;
            prev_oe = DATA_OE;
            @(negedge CLK);
        end
        REQ = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0; REQ_BE = 2'b11;
        REQ_WDATA = '0; DATA_IN = '0; DTACK = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({AS, UDS, LDS, RW, DATA_OE, DONE, ERR, READY} !== 8'b1111_0001) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", {AS, UDS, LDS, RW, DATA_OE, DONE, ERR, READY}, 8'b1111_0001);
        end
        total++;
        if (ADDR_OUT !== 23'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", ADDR_OUT); end
        total++;
        if (DATA_OUT !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", DATA_OUT); end
        total++;
        if (RDATA !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", RDATA); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_read_word();
        obs_t o;
        run_bus(1'b1, 23'h090001, 2'b11, 16'h0, 16'hBEEF, 2, 1'b0, 0, 20, o);
        total++;
        if (o.c_as !== 2) begin bad++; $display("FAIL rd_as_cycle got=%0d want=2", o.c_as); end
        total++;
        if (o.c_uds !== 2 || o.c_lds !== 2) begin
            bad++; $display("FAIL rd_ds_with_as got=%0d/%0d want=2/2", o.c_uds, o.c_lds);
        end
        total++;
        if (o.addr_bad !== 1'b0 || o.rw_bad !== 1'b0) begin
            bad++; $display("FAIL rd_addr_rw_stable got=%b%b want=00", o.addr_bad, o.rw_bad);
        end
        total++;
        if (o.rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h want=beef", o.rdata); end
        total++;
        if (o.ndone !== 1 || o.err !== 1'b0) begin
            bad++; $display("FAIL rd_done_err got=%0d/%b want=1/0", o.ndone, o.err);
        end
        total++;
        if (o.c_done - 1 !== 10) begin bad++; $display("FAIL rd_latency got=%0d want=10", o.c_done - 1); end
    endtask

    task automatic test_write_lower();
        obs_t o;
        run_bus(1'b0, 23'h000010, 2'b01, 16'h00A5, 16'h0000, 1, 1'b0, 0, 20, o);
        total++;
        if (o.c_as !== 2 || o.c_lds !== 3) begin
            bad++; $display("FAIL wr_lds_after_as got=%0d/%0d want=2/3", o.c_as, o.c_lds);
        end
        total++;
        if (o.c_uds !== -1) begin bad++; $display("FAIL wr_uds_idle got=%0d want=-1", o.c_uds); end
        total++;
        if (o.oe_pre !== 1'b1) begin bad++; $display("FAIL wr_oe_before_lds got=%b want=1", o.oe_pre); end
        total++;
        if (o.rw_bad !== 1'b0 || o.dout_bad !== 1'b0) begin
            bad++; $display("FAIL wr_rw_dout_stable got=%b%b want=00", o.rw_bad, o.dout_bad);
        end
        total++;
        if (o.ndone !== 1 || o.err !== 1'b0) begin
            bad++; $display("FAIL wr_done_err got=%0d/%b want=1/0", o.ndone, o.err);
        end
        total++;
        if (o.c_done - 1 !== 9) begin bad++; $display("FAIL wr_min_latency got=%0d want=9", o.c_done - 1); end
        total++;
        if (RDATA !== 16'hBEEF) begin bad++; $display("FAIL wr_rdata_kept got=%h want=beef", RDATA); end
        total++;
        if (DATA_OE !== 1'b0 || RW !== 1'b1) begin
            bad++; $display("FAIL wr_bus_idle got=%b%b want=01", DATA_OE, RW);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_bus(1'b1, 23'h7FFFFF, 2'b11, 16'h0, 16'h1234, -1, 1'b0, 0, 75, o);
        total++;
        if (o.c_rise - o.c_as !== 65) begin
            bad++; $display("FAIL to_as_low_len got=%0d want=65", o.c_rise - o.c_as);
        end
        total++;
        if (o.ndone !== 1 || o.err !== 1'b1) begin
            bad++; $display("FAIL to_done_err got=%0d/%b want=1/1", o.ndone, o.err);
        end
        total++;
        if (o.c_done - 1 !== 67) begin bad++; $display("FAIL to_latency got=%0d want=67", o.c_done - 1); end
        total++;
        if (READY !== 1'b1) begin bad++; $display("FAIL to_ready got=%b want=1", READY); end
    endtask

    task automatic test_stuck_dtack();
        obs_t o;
        int   acc;
        run_bus(1'b1, 23'h000100, 2'b11, 16'h0, 16'h5A5A, 1, 1'b1, 0, 80, o);
        total++;
        if (o.ndone !== 1 || o.err !== 1'b1) begin
            bad++; $display("FAIL stk_done_err got=%0d/%b want=1/1", o.ndone, o.err);
        end
        total++;
        if (o.c_done - 1 !== 70) begin bad++; $display("FAIL stk_latency got=%0d want=70", o.c_done - 1); end
        total++;
        if (o.rdata !== 16'h5A5A) begin bad++; $display("FAIL stk_rdata got=%h want=5a5a", o.rdata); end
        REQ = 1'b1; REQ_RW = 1'b1; REQ_BE = 2'b11;
        acc = 0;
        repeat (3) begin
            @(negedge CLK);
            if (AS === 1'b0 || READY !== 1'b0) acc++;
        end
        REQ = 1'b0;
        total++;
        if (acc !== 0) begin bad++; $display("FAIL stk_no_accept got=%0d want=0", acc); end
        DTACK = 1'b1;
        @(negedge CLK);
        total++;
        if (READY !== 1'b0) begin bad++; $display("FAIL stk_ready_1clk got=%b want=0", READY); end
        @(negedge CLK);
        total++;
        if (READY !== 1'b1) begin bad++; $display("FAIL stk_ready_2clk got=%b want=1", READY); end
        run_bus(1'b1, 23'h000101, 2'b11, 16'h0, 16'h0F0F, 1, 1'b0, 0, 15, o);
        total++;
        if (o.c_done - 1 !== 9 || o.err !== 1'b0 || o.rdata !== 16'h0F0F) begin
            bad++; $display("FAIL stk_recover_read got=%0d/%b/%h want=9/0/0f0f", o.c_done - 1, o.err, o.rdata);
        end
    endtask

    task automatic test_illegal_busy();
        obs_t o;
        run_bus(1'b1, 23'h000200, 2'b00, 16'h0, 16'h0, 1, 1'b0, 0, 10, o);
        total++;
        if (o.c_as !== -1 || o.c_uds !== -1 || o.c_lds !== -1) begin
            bad++; $display("FAIL ill_strobes got=%0d/%0d/%0d want=-1/-1/-1", o.c_as, o.c_uds, o.c_lds);
        end
        total++;
        if (o.ndone !== 1 || o.err !== 1'b1) begin
            bad++; $display("FAIL ill_done_err got=%0d/%b want=1/1", o.ndone, o.err);
        end
        total++;
        if (o.c_done - 1 !== 1) begin bad++; $display("FAIL ill_latency got=%0d want=1", o.c_done - 1); end
        run_bus(1'b1, 23'h000300, 2'b11, 16'h0, 16'hC0DE, 3, 1'b0, 5, 30, o);
        total++;
        if (o.ndone !== 1 || o.n_as_fall !== 1) begin
            bad++; $display("FAIL busy_single got=%0d/%0d want=1/1", o.ndone, o.n_as_fall);
        end
        total++;
        if (o.c_done - 1 !== 11 || o.rdata !== 16'hC0DE) begin
            bad++; $display("FAIL busy_read got=%0d/%h want=11/c0de", o.c_done - 1, o.rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        int dn;
        DTACK = 1'b1;
        @(negedge CLK);
        REQ = 1'b1; REQ_RW = 1'b0; REQ_ADDR = 23'h001234; REQ_BE = 2'b11; REQ_WDATA = 16'h1357;
        @(negedge CLK);
        REQ = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (AS !== 1'b0 || DATA_OE !== 1'b1) begin
            bad++; $display("FAIL rmw_in_wait got=%b%b want=01", AS, DATA_OE);
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({AS, UDS, LDS, DATA_OE, DONE, READY} !== 6'b111001) begin
            bad++; $display("FAIL rmw_after_rst got=%b want=111001", {AS, UDS, LDS, DATA_OE, DONE, READY});
        end
        total++;
        if (RDATA !== 16'h0) begin bad++; $display("FAIL rmw_rdata got=%h want=0", RDATA); end
        RST = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge CLK);
            if (DONE === 1'b1 || AS === 1'b0) dn++;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL rmw_quiet got=%0d want=0", dn); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_read_word();
        test_write_lower();
        test_timeout();
        test_stuck_dtack();
        test_illegal_busy();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
